// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, same-cycle read bypass,
// a per-register pending scoreboard and a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                w0_en,
  input  logic [AW-1:0]       w0_addr,
  input  logic [XLEN-1:0]     w0_data,
  input  logic                w1_en,
  input  logic [AW-1:0]       w1_addr,
  input  logic [XLEN-1:0]     w1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                clr_busy
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           r_state, w_state_next;
  logic [AW-1:0]    r_idx, w_idx_next;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend, w_pend_next;
  logic             w_idle, w_clr_pend;
  logic             w_w0_ok, w_w1_ok, w_iss_ok;

  assign w_idle   = (r_state == S_IDLE);
  assign clr_busy = (r_state == S_SWEEP);

  // Ports are gated off during a sweep and register 0 is immutable when hardwired.
  assign w_w0_ok  = w_idle & w0_en  & ~((ZERO_REG != 0) && (w0_addr  == '0));
  assign w_w1_ok  = w_idle & w1_en  & ~((ZERO_REG != 0) && (w1_addr  == '0));
  assign w_iss_ok = w_idle & iss_en & ~((ZERO_REG != 0) && (iss_addr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_pend  <= w_pend_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_clr_pend   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_next = S_SWEEP;
          w_idx_next   = '0;
          w_clr_pend   = 1'b1;
        end
      end
      S_SWEEP: begin
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Issue is applied after the writeback clear so a new producer keeps the bit set.
  always_comb begin
    w_pend_next = r_pend;
    if (w_clr_pend) begin
      w_pend_next = '0;
    end else begin
      if (w_w0_ok)  w_pend_next[w0_addr]  = 1'b0;
      if (w_iss_ok) w_pend_next[iss_addr] = 1'b1;
    end
  end

  // w1 is assigned last so it takes the entry when both ports hit the same address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NREGS; j++) r_regs[j] <= '0;
    end else if (r_state == S_SWEEP) begin
      r_regs[r_idx] <= '0;
    end else begin
      if (w_w0_ok) r_regs[w0_addr] <= w0_data;
      if (w_w1_ok) r_regs[w1_addr] <= w1_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_rdata;
      logic            w_zero;

      assign w_ra   = rd_addr[gi*AW +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

      always_comb begin
        w_rdata = r_regs[w_ra];
        if (w_zero) begin
          w_rdata = '0;
        end else if (w_idle && w1_en && (w1_addr == w_ra)) begin
          w_rdata = w1_data;
        end else if (w_idle && w0_en && (w0_addr == w_ra)) begin
          w_rdata = w0_data;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = w_rdata;
      assign rd_pend[gi] = r_pend[w_ra] & ~(w0_en & (w0_addr == w_ra));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an abstract per-cycle model,
// plus a small 4-read-port, 16-bit instance for the wide-read bypass case.
module tb_regfile_mp;
  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        w0_en, w1_en, iss_en, clr_req, clr_busy;
  logic [4:0]  w0_addr, w1_addr, iss_addr;
  logic [31:0] w0_data, w1_data;

  logic [15:0] d4_rd_addr;
  logic [63:0] d4_rd_data;
  logic [3:0]  d4_rd_pend;
  logic        d4_w0_en, d4_w1_en, d4_iss_en, d4_clr_req, d4_clr_busy;
  logic [3:0]  d4_w0_addr, d4_w1_addr, d4_iss_addr;
  logic [15:0] d4_w0_data, d4_w1_data;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.XLEN(16), .NREGS(16), .NRD(4), .ZERO_REG(1)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .rd_addr(d4_rd_addr), .rd_data(d4_rd_data), .rd_pend(d4_rd_pend),
    .w0_en(d4_w0_en), .w0_addr(d4_w0_addr), .w0_data(d4_w0_data),
    .w1_en(d4_w1_en), .w1_addr(d4_w1_addr), .w1_data(d4_w1_data),
    .iss_en(d4_iss_en), .iss_addr(d4_iss_addr), .clr_req(d4_clr_req), .clr_busy(d4_clr_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: architectural contents, pending set and cycles left in a sweep.
  logic [31:0] m_mem  [NREGS];
  logic        m_pend [NREGS];
  int          m_sweep_left;

  task automatic model_reset();
    for (int j = 0; j < NREGS; j++) begin
      m_mem[j]  = '0;
      m_pend[j] = 1'b0;
    end
    m_sweep_left = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_sweep_left == 0) begin
      if (w1_en && w1_addr == a) return w1_data;
      if (w0_en && w0_addr == a) return w0_data;
    end
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    return m_pend[a] && !(w0_en && w0_addr == a);
  endfunction

  task automatic model_edge();
    if (m_sweep_left > 0) begin
      m_mem[NREGS - m_sweep_left] = '0;
      m_sweep_left--;
    end else if (clr_req) begin
      for (int j = 0; j < NREGS; j++) m_pend[j] = 1'b0;
      m_sweep_left = NREGS;
    end else begin
      if (w0_en && w0_addr != 0) begin
        m_mem[w0_addr]  = w0_data;
        m_pend[w0_addr] = 1'b0;
      end
      if (w1_en && w1_addr != 0) m_mem[w1_addr] = w1_data;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    w0_en = 0; w1_en = 0; iss_en = 0; clr_req = 0;
    w0_addr = 0; w1_addr = 0; iss_addr = 0; w0_data = 0; w1_data = 0;
  endtask

  function automatic logic [31:0] port_data(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  // One cycle: compare combinational outputs to the model, then advance both on the edge.
  task automatic step();
    logic [4:0] a;
    #1;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      check("rd_data", {32'h0, port_data(p)}, {32'h0, exp_rd(a)});
      check("rd_pend", {63'h0, rd_pend[p]}, {63'h0, exp_pend(a)});
    end
    check("clr_busy", {63'h0, clr_busy}, {63'h0, (m_sweep_left > 0)});
    $display("t=%0t rd=%0d/%0d w0=%b:%0d w1=%b:%0d iss=%b:%0d clr=%b busy=%b",
             $time, rd_addr[4:0], rd_addr[9:5], w0_en, w0_addr, w1_en, w1_addr,
             iss_en, iss_addr, clr_req, clr_busy);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int cnt;

  initial begin
    idle();
    rd_addr = '0;
    d4_rd_addr = '0; d4_w0_en = 0; d4_w1_en = 0; d4_iss_en = 0; d4_clr_req = 0;
    d4_w0_addr = 0; d4_w1_addr = 0; d4_iss_addr = 0; d4_w0_data = 0; d4_w1_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_busy", {63'h0, clr_busy}, 64'h0);
    rd_addr = {5'd7, 5'd5};
    #1;
    check("rst_r5", {32'h0, port_data(0)}, 64'h0);
    check("rst_pend", {62'h0, rd_pend}, 64'h0);
    step();

    w0_en = 1; w0_addr = 5; w0_data = 32'hDEADBEEF;
    step();
    idle();
    #1 check("r5", {32'h0, port_data(0)}, 64'hDEADBEEF);
    step();

    w0_en = 1; w0_addr = 0; w0_data = 32'h1;
    rd_addr = {5'd5, 5'd0};
    #1 check("r0_byp", {32'h0, port_data(0)}, 64'h0);
    step();
    idle();
    #1 check("r0", {32'h0, port_data(0)}, 64'h0);
    step();

    w0_en = 1; w0_addr = 7; w0_data = 32'h11;
    w1_en = 1; w1_addr = 7; w1_data = 32'h22;
    rd_addr = {5'd0, 5'd7};
    #1 check("r7_byp", {32'h0, port_data(0)}, 64'h22);
    step();
    idle();
    #1 check("r7", {32'h0, port_data(0)}, 64'h22);
    step();

    iss_en = 1; iss_addr = 3;
    rd_addr = {5'd0, 5'd3};
    step();
    idle();
    #1 check("r3_pend", {63'h0, rd_pend[0]}, 64'h1);
    w0_en = 1; w0_addr = 3; w0_data = 32'h55;
    #1 check("r3_wb_pend", {63'h0, rd_pend[0]}, 64'h0);
    check("r3_wb_data", {32'h0, port_data(0)}, 64'h55);
    step();
    idle();
    #1 check("r3_cleared", {63'h0, rd_pend[0]}, 64'h0);
    step();

    iss_en = 1; iss_addr = 9; w0_en = 1; w0_addr = 9; w0_data = 32'h9;
    rd_addr = {5'd9, 5'd3};
    step();
    idle();
    #1 check("r9_pend", {63'h0, rd_pend[1]}, 64'h1);
    step();

    for (int i = 1; i < NREGS; i++) begin
      w0_en = 1; w0_addr = 5'(i); w0_data = 32'(i);
      iss_en = (i == 2); iss_addr = 5'd2;
      rd_addr = {5'(i), 5'(i - 1)};
      step();
    end
    idle();
    clr_req = 1;
    step();
    clr_req = 0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      w0_en = (k == 10); w0_addr = 5'd4; w0_data = 32'hABCD;
      clr_req = (k >= 20 && k < 25);
      rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      #1;
      if (!clr_busy) break;
      cnt++;
      step();
    end
    check("sweep_len", 64'(cnt), 64'd32);
    idle();
    for (int a = 0; a < NREGS; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      check("swept_lo", {32'h0, port_data(0)}, 64'h0);
      check("swept_hi", {32'h0, port_data(1)}, 64'h0);
      check("swept_pend", {62'h0, rd_pend}, 64'h0);
      step();
    end

    w0_en = 1; w0_addr = 6; w0_data = 32'h66;
    step();
    idle();
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (9) step();
    #2 reset_n = 1'b0;
    #1 check("abort_busy", {63'h0, clr_busy}, 64'h0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd_addr = {5'd7, 5'd6};
    #1;
    check("abort_r6", {32'h0, port_data(0)}, 64'h0);
    check("abort_r7", {32'h0, port_data(1)}, 64'h0);
    step();
    step();

    for (int n = 0; n < 600; n++) begin
      rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      clr_req = ($urandom_range(0, 63) == 0);
      w0_en = !clr_req && $urandom_range(0, 1) == 1;
      w1_en = !clr_req && $urandom_range(0, 3) == 0;
      iss_en = !clr_req && $urandom_range(0, 2) == 0;
      w0_addr = 5'($urandom_range(0, 31));
      w1_addr = ($urandom_range(0, 3) == 0) ? w0_addr : 5'($urandom_range(0, 31));
      iss_addr = ($urandom_range(0, 3) == 0) ? w0_addr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) rd_addr[4:0] = w0_addr;
      w0_data = $urandom;
      w1_data = $urandom;
      step();
    end
    idle();

    for (int i = 1; i <= 3; i++) begin
      d4_w0_en = 1; d4_w0_addr = 4'(i); d4_w0_data = 16'(16'h1111 * i);
      @(posedge clk);
      #1;
    end
    d4_w0_en = 0;
    d4_rd_addr = {4'd1, 4'd3, 4'd2, 4'd1};
    d4_w1_en = 1; d4_w1_addr = 2; d4_w1_data = 16'hBEEF;
    #1;
    check("d4_p0", {48'h0, d4_rd_data[15:0]},  64'h1111);
    check("d4_p1", {48'h0, d4_rd_data[31:16]}, 64'hBEEF);
    check("d4_p2", {48'h0, d4_rd_data[47:32]}, 64'h3333);
    check("d4_p3", {48'h0, d4_rd_data[63:48]}, 64'h1111);
    check("d4_pend", {60'h0, d4_rd_pend}, 64'h0);
    @(posedge clk);
    #1 d4_w1_en = 0;
    #1;
    check("d4_r2", {48'h0, d4_rd_data[31:16]}, 64'hBEEF);
    check("d4_busy", {63'h0, d4_clr_busy}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core. Generalises the single-write, two-read file.
- Adds configurable width, depth and read-port count, and a second write port with fixed priority.
- Adds a per-register pending scoreboard for hazard detection and a hardware clear sequencer that zeroes the array one entry per cycle.
- Sits between decode (reads, issue marking) and writeback/late-ALU (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, at least 2. AW = log2(NREGS).
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  flattened read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  flattened read data, combinational.
- rd_pend  out  NRD  per read port: addressed register is pending, combinational.
- w0_en  in  1  write port 0 enable (writeback; also clears pending).
- w0_addr  in  AW  write port 0 address.
- w0_data  in  XLEN  write port 0 data.
- w1_en  in  1  write port 1 enable (late-ALU; higher priority, does not clear pending).
- w1_addr  in  AW  write port 1 address.
- w1_data  in  XLEN  write port 1 data.
- iss_en  in  1  mark iss_addr pending.
- iss_addr  in  AW  destination register being issued.
- clr_req  in  1  start clear sweep; single-cycle pulse or level.
- clr_busy  out  1  sweep in progress.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers 0.
  - All pending bits 0.
  - FSM in IDLE, sweep index 0.
  - clr_busy = 0.
- Writes commit on the rising edge.
  - Both ports enabled to the same address: w1 wins.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Reads are combinational with same-cycle bypass.
  - If w1_en and w1_addr == rd_addr[i], return w1_data.
  - Otherwise, if w0_en and w0_addr matches, return w0_data.
  - Otherwise return the array entry.
  - Address 0 with ZERO_REG=1 always returns 0; bypass never applies to it.
  - In IDLE, read latency is 0 cycles.
- Scoreboard (NREGS pending bits):
  - iss_en sets pending[iss_addr] on the edge.
  - w0_en clears pending[w0_addr] on the edge.
  - Issue and w0 to the same address in the same cycle: set wins, because the new producer overrides.
  - Issue to register 0 with ZERO_REG=1 is ignored.
  - w1 never changes pending bits.
  - rd_pend[i] = pending[rd_addr[i]] & ~(w0_en & w0_addr == rd_addr[i]). A same-cycle writeback bypass therefore shows not-pending.
- Clear FSM:
  - States IDLE and SWEEP.
  - IDLE → SWEEP on clr_req. On that edge all pending bits are cleared and the index is set to 0.
  - In SWEEP, regs[index] ← 0 each cycle, then index increments.
  - When index == NREGS-1 is written, return to IDLE. The sweep occupies exactly NREGS cycles with clr_busy=1.
  - clr_req during SWEEP is ignored; there is no restart.
  - During SWEEP, w0/w1/iss are dropped and read bypass is disabled. Reads return array contents, so already-swept entries read 0.
  - reset_n asserted mid-sweep aborts immediately and the full reset state applies.
- Index counter width is AW. It does not wrap during a sweep because exit happens at NREGS-1.

Test Plan:
- Reset, then w0 writes 0xDEADBEEF to r5; next cycle read r5 on port 0 → 0xDEADBEEF. Read r0 → 0. Write 0x1 to r0, then read r0 → 0.
- w0 (r7, 0x11) and w1 (r7, 0x22) in the same cycle: same-cycle read of r7 → 0x22; the following cycle r7 → 0x22.
- iss_en r3, then read r3 → rd_pend=1. Next cycle w0 r3 = 0x55: same-cycle rd_pend=0 and rd_data=0x55. After the edge, pending is 0. iss_en and w0 to r9 in the same cycle → r9 pending after the edge.
- Fill r1..r31 with their own index, then pulse clr_req: clr_busy high for exactly 32 cycles. A w0 write mid-sweep is dropped. After the sweep all registers read 0 and all pending bits are 0.
- Start a sweep, assert reset_n low at cycle 10 → clr_busy falls immediately (asynchronous). After release, registers read 0 and the FSM is IDLE.
- NRD=4, XLEN=16, NREGS=16: four ports read r1, r2, r3, r1 simultaneously with w1 to r2 → r2 shows bypassed data and the other ports show stored values.
